// File: rtl/rom_read_arbiter.sv
// Two-channel read front end for a dual-port ROM: round-robin arbitration, one ROM port enabled per cycle.
// Latency: accept to rsp_valid is 3 cycles uncontended, 4 for the arbitration loser; rsp held stable while rsp_ready is low.
module rom_read_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_a,
    input  logic [ADDR_W-1:0] req_addr_a,
    output logic              req_ready_a,
    input  logic              req_valid_b,
    input  logic [ADDR_W-1:0] req_addr_b,
    output logic              req_ready_b,
    output logic              rsp_valid_a,
    output logic [DATA_W-1:0] rsp_data_a,
    input  logic              rsp_ready_a,
    output logic              rsp_valid_b,
    output logic [DATA_W-1:0] rsp_data_b,
    input  logic              rsp_ready_b,
    output logic              ena,
    output logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] data_outa,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] data_outb
);
    typedef enum logic [1:0] {IDLE, PEND, ISSUED, RESP} state_t;

    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

    state_t            st_a, st_b, nxt_a, nxt_b;
    logic [ADDR_W-1:0] pend_addr_a, pend_addr_b, nxt_pend_a, nxt_pend_b;
    logic              rr_last, nxt_rr, gnt_a, gnt_b;

    assign req_ready_a = (st_a == IDLE);
    assign req_ready_b = (st_b == IDLE);

    // Grants are computed for the next cycle so ena/enb can be registered and
    // still rise in the first PEND cycle; a high ena means "granted this cycle".
    always_comb begin
        nxt_a      = st_a;
        nxt_pend_a = pend_addr_a;
        case (st_a)
            IDLE: begin
                if (req_valid_a) begin
                    nxt_a      = PEND;
                    nxt_pend_a = req_addr_a;
                end
            end
            PEND:    if (ena) nxt_a = ISSUED;
            ISSUED:  nxt_a = RESP;
            RESP:    if (rsp_ready_a) nxt_a = IDLE;
            default: nxt_a = IDLE;
        endcase

        nxt_b      = st_b;
        nxt_pend_b = pend_addr_b;
        case (st_b)
            IDLE: begin
                if (req_valid_b) begin
                    nxt_b      = PEND;
                    nxt_pend_b = req_addr_b;
                end
            end
            PEND:    if (enb) nxt_b = ISSUED;
            ISSUED:  nxt_b = RESP;
            RESP:    if (rsp_ready_b) nxt_b = IDLE;
            default: nxt_b = IDLE;
        endcase

        // rr_last only moves when a genuine tie was resolved this cycle.
        nxt_rr = (st_a == PEND && st_b == PEND) ? (ena ? RR_A : RR_B) : rr_last;
        gnt_a  = (nxt_a == PEND) && (nxt_b != PEND || nxt_rr == RR_B);
        gnt_b  = (nxt_b == PEND) && (nxt_a != PEND || nxt_rr == RR_A);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_a        <= IDLE;
            st_b        <= IDLE;
            pend_addr_a <= '0;
            pend_addr_b <= '0;
            rr_last     <= RR_B;
            ena         <= 1'b0;
            enb         <= 1'b0;
            addra       <= '0;
            addrb       <= '0;
            rsp_valid_a <= 1'b0;
            rsp_valid_b <= 1'b0;
            rsp_data_a  <= '0;
            rsp_data_b  <= '0;
        end else begin
            st_a        <= nxt_a;
            st_b        <= nxt_b;
            pend_addr_a <= nxt_pend_a;
            pend_addr_b <= nxt_pend_b;
            rr_last     <= nxt_rr;
            ena         <= gnt_a;
            enb         <= gnt_b;
            if (gnt_a) addra <= nxt_pend_a;
            if (gnt_b) addrb <= nxt_pend_b;
            if (st_a == ISSUED) rsp_data_a <= data_outa;
            if (st_b == ISSUED) rsp_data_b <= data_outb;
            rsp_valid_a <= (nxt_a == RESP);
            rsp_valid_b <= (nxt_b == RESP);
        end
    end
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter with a behavioural ROM and a cycle-level protocol model.
module tb_rom_read_arbiter;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic [ADDR_W-1:0] req_addr_a = '0, req_addr_b = '0;
    logic              req_ready_a, req_ready_b;
    logic              rsp_valid_a, rsp_valid_b;
    logic [DATA_W-1:0] rsp_data_a, rsp_data_b;
    logic              rsp_ready_a = 1'b1, rsp_ready_b = 1'b1;
    logic              ena, enb;
    logic [ADDR_W-1:0] addra, addrb;
    logic [DATA_W-1:0] data_outa = '0, data_outb = '0;

    logic [DATA_W-1:0] rom_img [8] = '{4'h1, 4'h3, 4'hA, 4'h6, 4'h7, 4'hD, 4'h9, 4'hB};

    rom_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid_a(req_valid_a), .req_addr_a(req_addr_a), .req_ready_a(req_ready_a),
        .req_valid_b(req_valid_b), .req_addr_b(req_addr_b), .req_ready_b(req_ready_b),
        .rsp_valid_a(rsp_valid_a), .rsp_data_a(rsp_data_a), .rsp_ready_a(rsp_ready_a),
        .rsp_valid_b(rsp_valid_b), .rsp_data_b(rsp_data_b), .rsp_ready_b(rsp_ready_b),
        .ena(ena), .addra(addra), .data_outa(data_outa),
        .enb(enb), .addrb(addrb), .data_outb(data_outb)
    );

    always #5 clk = ~clk;

    // Registered ROM: word appears one cycle after its enable.
    always @(posedge clk) begin
        if (ena) data_outa <= rom_img[addra];
        if (enb) data_outb <= rom_img[addrb];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Protocol model: per channel, an accepted request waits for a grant, its
    // response is due two cycles after the grant, and the channel is busy until
    // the response is taken. Ties go to the channel that did not win the last tie.
    bit                model_on = 1'b0;
    bit                waiting [2];
    logic [ADDR_W-1:0] wait_addr [2];
    bit                rsp_pend [2];
    int                due [2];
    logic [ADDR_W-1:0] last_addr [2];
    bit                last_tie;
    bit                b2b = 1'b0;
    int                last_rsp [2];
    logic [DATA_W-1:0] exp_q_a [$];
    logic [DATA_W-1:0] exp_q_b [$];

    always @(negedge clk) begin
        logic              en [2], vld [2], rdy [2], rrdy [2], rv [2];
        logic [ADDR_W-1:0] ad [2], ra [2];
        logic [DATA_W-1:0] dat [2];
        logic [DATA_W-1:0] head;
        bit                exp_en [2], exp_rdy [2], exp_v;
        string             s;
        en = '{ena, enb};            vld = '{rsp_valid_a, rsp_valid_b};
        rdy = '{req_ready_a, req_ready_b}; rrdy = '{rsp_ready_a, rsp_ready_b};
        rv = '{req_valid_a, req_valid_b};  ad = '{addra, addrb};
        ra = '{req_addr_a, req_addr_b};    dat = '{rsp_data_a, rsp_data_b};
        if (rst) begin
            model_on = 1'b1;
            last_tie = 1'b1;
            for (int c = 0; c < 2; c++) begin
                waiting[c] = 1'b0; rsp_pend[c] = 1'b0; last_addr[c] = '0; last_rsp[c] = -1;
            end
            exp_q_a.delete();
            exp_q_b.delete();
        end else if (model_on) begin
            chk("en_mutex", int'(ena & enb), 0);
            for (int c = 0; c < 2; c++) exp_rdy[c] = !(waiting[c] || rsp_pend[c]);
            exp_en[0] = waiting[0] && (!waiting[1] || last_tie);
            exp_en[1] = waiting[1] && (!waiting[0] || !last_tie);
            if (waiting[0] && waiting[1]) last_tie = exp_en[1];
            for (int c = 0; c < 2; c++) begin
                s = (c == 0) ? "a" : "b";
                chk({"en_", s}, int'(en[c]), int'(exp_en[c]));
                chk({"req_ready_", s}, int'(rdy[c]), int'(exp_rdy[c]));
                if (exp_en[c]) begin
                    waiting[c]   = 1'b0;
                    rsp_pend[c]  = 1'b1;
                    due[c]       = cyc + 2;
                    last_addr[c] = wait_addr[c];
                end
                chk({"addr_", s}, int'(ad[c]), int'(last_addr[c]));
                exp_v = rsp_pend[c] && (cyc >= due[c]);
                chk({"rsp_valid_", s}, int'(vld[c]), int'(exp_v));
                if (exp_v) begin
                    head = (c == 0) ? ((exp_q_a.size() > 0) ? exp_q_a[0] : 'x)
                                    : ((exp_q_b.size() > 0) ? exp_q_b[0] : 'x);
                    chk({"rsp_data_", s}, int'(dat[c]), int'(head));
                    if (rrdy[c]) begin
                        if (c == 0) void'(exp_q_a.pop_front());
                        else        void'(exp_q_b.pop_front());
                        rsp_pend[c] = 1'b0;
                        if (b2b && c == 0 && last_rsp[0] >= 0)
                            chk("b2b_spacing", cyc - last_rsp[0], 4);
                        last_rsp[c] = cyc;
                    end
                end
                if (rv[c] && exp_rdy[c]) begin
                    waiting[c]   = 1'b1;
                    wait_addr[c] = ra[c];
                    if (c == 0) exp_q_a.push_back(rom_img[ra[c]]);
                    else        exp_q_b.push_back(rom_img[ra[c]]);
                end
            end
        end
    end

    task automatic issue(input int c, input logic [ADDR_W-1:0] addr);
        int   n;
        logic r;
        n = 0;
        @(posedge clk); #1;
        if (c == 0) begin req_valid_a = 1'b1; req_addr_a = addr; end
        else        begin req_valid_b = 1'b1; req_addr_b = addr; end
        do begin
            @(negedge clk);
            r = (c == 0) ? req_ready_a : req_ready_b;
            n++;
        end while (!r && n < 60);
        if (!r) chk((c == 0) ? "accept_timeout_a" : "accept_timeout_b", int'(r), 1);
        @(posedge clk); #1;
        if (c == 0) req_valid_a = 1'b0;
        else        req_valid_b = 1'b0;
    endtask

    task automatic wait_idle();
        int busy;
        int n;
        n = 0;
        busy = int'(waiting[0] || waiting[1] || rsp_pend[0] || rsp_pend[1]);
        while (busy != 0 && n < 100) begin
            @(negedge clk);
            n++;
            busy = int'(waiting[0] || waiting[1] || rsp_pend[0] || rsp_pend[1]);
        end
        if (busy != 0) chk("idle_timeout", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_chan(input int c, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(c, ADDR_W'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_data_a", int'(rsp_data_a), 0);
        chk("reset_rsp_data_b", int'(rsp_data_b), 0);
        chk("reset_rsp_valid_a", int'(rsp_valid_a), 0);
        chk("reset_req_ready_a", int'(req_ready_a), 1);
        chk("reset_addrb", int'(addrb), 0);

        // Single read, then a simultaneous pair, then the round-robin repeat.
        issue(0, 3'd2);
        wait_idle();
        fork issue(0, 3'd5); issue(1, 3'd7); join
        wait_idle();
        fork issue(0, 3'd0); issue(1, 3'd1); join
        wait_idle();

        // Backpressure on A while B completes.
        rsp_ready_a = 1'b0;
        issue(0, 3'd6);
        issue(1, 3'd3);
        repeat (5) @(posedge clk);
        #1 rsp_ready_a = 1'b1;
        wait_idle();

        // Reset while A is in ISSUED.
        issue(0, 3'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midreset_rsp_valid_a", int'(rsp_valid_a), 0);
        chk("midreset_rsp_data_a", int'(rsp_data_a), 0);
        chk("midreset_addra", int'(addra), 0);
        chk("midreset_ena", int'(ena), 0);
        repeat (4) @(posedge clk);
        issue(0, 3'd4);
        wait_idle();

        // Back-to-back full image on A.
        b2b = 1'b1;
        last_rsp[0] = -1;
        for (int i = 0; i < 8; i++) issue(0, ADDR_W'(i));
        wait_idle();
        b2b = 1'b0;

        // Random traffic with random response backpressure.
        fork
            rand_chan(0, 25);
            rand_chan(1, 25);
            begin
                repeat (300) begin
                    @(posedge clk); #1;
                    rsp_ready_a = ($urandom_range(0, 3) != 0);
                    rsp_ready_b = ($urandom_range(0, 3) != 0);
                end
                rsp_ready_a = 1'b1;
                rsp_ready_b = 1'b1;
            end
        join
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
